caseg_disp_arbiter: RTL
=======================

Name: caseg_disp_arbiter

Overview:
- Shares one 8-digit seven-segment display between a background source (src0, e.g. time of day) and two overlay requesters (src1 low priority, src2 high priority, e.g. settings menu and alarm).
- Drives bit_7..bit_0 and dp_en of the downstream digit scanner, with request/grant handshake, minimum overlay hold time and a blank gap on every source switch.
- Sits between the application counters and the scan/segment driver.

Parameters:
TICK_DIV, 50000, sclk cycles per 1 ms tick (50 MHz)
HOLD_MS, 2000, minimum ms an overlay source is shown before it may be released
BLANK_MS, 100, ms of blank display inserted on every source switch

Ports:
sclk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
src0_digits  in  32  background digit codes {d7..d0}, 4 bits each
src0_dp  in  8  background decimal-point enables
req  in  2  req[0]=src1 request, req[1]=src2 request; level, held while wanted
src1_digits  in  32  src1 digit codes
src1_dp  in  8  src1 dp enables
src2_digits  in  32  src2 digit codes
src2_dp  in  8  src2 dp enables
gnt  out  2  gnt[0]=src1 shown, gnt[1]=src2 shown
bit_7..bit_0  out  4 each  digit codes to scanner (bit_7 = digits[31:28] ... bit_0 = digits[3:0])
dp_en  out  8  dp enables to scanner
active_src  out  2  0=src0, 1=src1, 2=src2, 3=blank

Behaviour:
- Reset (async, rst=1): state BG, all bit_x=4'd10 (blank code), dp_en=0, gnt=0, active_src=0, all counters 0. Reset mid-operation aborts any hold/blank immediately.
- ms tick: divider counts 0..TICK_DIV-1 and pulses on TICK_DIV-1. ms counter increments per tick, saturating at max(HOLD_MS,BLANK_MS). Divider and ms counter clear on every state entry.
- States:
  - BG: show src0. Any req -> BLANK; target = src2 if req[1], else src1.
  - BLANK: outputs all 4'd10, dp_en=0, gnt=0, active_src=3. Exits on the cycle ms count reaches BLANK_MS (exactly BLANK_MS*TICK_DIV cycles). At exit the target is re-evaluated: highest pending req wins, else BG.
  - SHOW1: show src1, gnt=01.
    - req[1] -> BLANK target src2 immediately; preemption ignores hold.
    - Else when ms>=HOLD_MS and req[0]=0 -> BLANK target BG.
  - SHOW2: show src2, gnt=10. When ms>=HOLD_MS and req[1]=0 -> BLANK, target src1 if req[0], else BG. Never preempted.
- Output latency: all outputs registered. Digit/dp content follows the selected source's inputs with 1 cycle latency, live (not latched). gnt/active_src change on the same edge as the state.
- Request dropped before hold elapses: display stays on that source until HOLD_MS, then releases.
- Simultaneous req[0]&req[1]: src2 wins.
- Request re-asserted during BLANK toward BG: taken at BLANK exit; no second blank is inserted.
- HOLD_MS=0: release as soon as req drops (next cycle).

Decomposition:
- Package caseg_pkg: state encoding (BG, BLANK, SHOW1, SHOW2), BLANK_CODE=4'd10, active_src codes.
- Sub-module ms_tick_gen (TICK_DIV param, sync clear input, tick output), reused by other display blocks.

Test Plan (TICK_DIV=4, HOLD_MS=3, BLANK_MS=2):
1. Reset release, src0_digits=32'h1234_5678, src0_dp=8'h04, no req -> first cycle: all bit_x=4'hA, dp 0. One cycle later: bit_7=1..bit_0=8, dp_en=8'h04, active_src=0, gnt=0.
2. req=01 single cycle in BG -> 8 cycles BLANK (active_src=3, all 4'hA). Then SHOW1, gnt=01 for exactly 12 cycles (hold). Then 8 cycles BLANK, then BG.
3. req=01 held. After 5 cycles in SHOW1, assert req[1] -> next edge BLANK, gnt=00. After 8 cycles SHOW2, gnt=10, shows src2_digits.
4. req=11 asserted together from BG -> SHOW2 after blank. Drop req[1] with req[0] still high after hold -> BLANK 8 cycles -> SHOW1.
5. In SHOW2, drop req[1] at cycle 1 -> stays SHOW2 until 12 cycles total, then BLANK -> BG.
6. Assert rst mid-BLANK and mid-SHOW1 -> same cycle: outputs 4'hA, dp 0, gnt 0, state BG. After release, src0 content appears 1 cycle later.

Source files
------------

// File: rtl/caseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter family.
package caseg_pkg;

  // Arbiter states: background, blank gap, low-priority overlay, high-priority overlay
  typedef enum logic [1:0] {
    ST_BG    = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW1 = 2'd2,
    ST_SHOW2 = 2'd3
  } state_e;

  // Source codes as reported on active_src (also used as the pending target)
  typedef enum logic [1:0] {
    SRC_BG    = 2'd0,
    SRC_1     = 2'd1,
    SRC_2     = 2'd2,
    SRC_BLANK = 2'd3
  } src_e;

  // Digit code the scanner renders as an unlit digit
  localparam logic [3:0]  BLANK_CODE   = 4'd10;
  localparam logic [31:0] BLANK_DIGITS = {8{BLANK_CODE}};

  // Choose the state that follows a blank gap. A source is pending when it is
  // requested right now or was recorded as the target on entry to the gap;
  // the highest pending source wins, otherwise the background comes back.
  function automatic state_e exit_blank_state(input logic [1:0] req, input src_e target);
    if (req[1] || (target == SRC_2)) begin
      return ST_SHOW2;
    end
    if (req[0] || (target == SRC_1)) begin
      return ST_SHOW1;
    end
    return ST_BG;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: divides the system clock by TICK_DIV and emits
// a one-cycle pulse on the last count. A synchronous clear restarts the count.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign tick_o = (div_q == DIV_LAST);

  // Count 0..TICK_DIV-1 and wrap; a clear forces the next count back to zero
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (clr_i || tick_o) begin
      div_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/caseg_disp_arbiter.sv
// Shares one 8-digit seven-segment display between a background source and
// two overlay requesters, with a minimum overlay hold time and a blank gap
// inserted on every source switch. All outputs are registered.
module caseg_disp_arbiter #(
  parameter int TICK_DIV = 50000,
  parameter int HOLD_MS  = 2000,
  parameter int BLANK_MS = 100
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [31:0] src0_digits,
  input  logic [7:0]  src0_dp,
  input  logic [1:0]  req,
  input  logic [31:0] src1_digits,
  input  logic [7:0]  src1_dp,
  input  logic [31:0] src2_digits,
  input  logic [7:0]  src2_dp,
  output logic [1:0]  gnt,
  output logic [3:0]  bit_7,
  output logic [3:0]  bit_6,
  output logic [3:0]  bit_5,
  output logic [3:0]  bit_4,
  output logic [3:0]  bit_3,
  output logic [3:0]  bit_2,
  output logic [3:0]  bit_1,
  output logic [3:0]  bit_0,
  output logic [7:0]  dp_en,
  output logic [1:0]  active_src
);

  import caseg_pkg::*;

  // The ms counter saturates at the larger of the two limits; one spare
  // value keeps ms+1 representable for the early-reach comparisons.
  localparam int MS_MAX = (HOLD_MS > BLANK_MS) ? HOLD_MS : BLANK_MS;
  localparam int MS_W   = $clog2(MS_MAX + 2);
  localparam logic [MS_W-1:0] MS_SAT    = MS_W'(MS_MAX);
  localparam logic [MS_W-1:0] HOLD_LIM  = MS_W'(HOLD_MS);
  localparam logic [MS_W-1:0] BLANK_LIM = MS_W'(BLANK_MS);

  state_e state_q, state_d;
  src_e   target_q, target_d;

  logic [MS_W-1:0] ms_q, ms_d;
  logic [MS_W-1:0] msInc;
  logic            msTick;
  logic            clearTimers;
  logic            holdDone;
  logic            blankDone;

  logic [31:0] digits_q, digits_d;
  logic [7:0]  dp_q, dp_d;
  logic [1:0]  gnt_q, gnt_d;
  src_e        active_q, active_d;

  // Timers restart on every state entry
  assign clearTimers = (state_d != state_q);

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk_i (sclk),
    .rst_i (rst),
    .clr_i (clearTimers),
    .tick_o(msTick)
  );

  // A limit counts as reached on the cycle whose tick brings ms up to it, so a
  // limit of N ms lasts exactly N*TICK_DIV cycles from state entry.
  assign msInc     = ms_q + MS_W'(1);
  assign holdDone  = (ms_q >= HOLD_LIM)  || (msTick && (msInc >= HOLD_LIM));
  assign blankDone = (ms_q >= BLANK_LIM) || (msTick && (msInc >= BLANK_LIM));

  // Millisecond count: clears on state entry, advances per tick, saturates
  always_comb begin
    ms_d = ms_q;
    if (clearTimers) begin
      ms_d = '0;
    end else if (msTick && (ms_q != MS_SAT)) begin
      ms_d = msInc;
    end
  end

  // Next-state logic: overlays enter through a blank gap; src2 preempts src1
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_BG: begin
        if (req[1]) begin
          state_d  = ST_BLANK;
          target_d = SRC_2;
        end else if (req[0]) begin
          state_d  = ST_BLANK;
          target_d = SRC_1;
        end
      end
      ST_BLANK: begin
        if (blankDone) begin
          state_d = exit_blank_state(req, target_q);
        end
      end
      ST_SHOW1: begin
        if (req[1]) begin
          state_d  = ST_BLANK;
          target_d = SRC_2;
        end else if (holdDone && !req[0]) begin
          state_d  = ST_BLANK;
          target_d = SRC_BG;
        end
      end
      ST_SHOW2: begin
        if (holdDone && !req[1]) begin
          state_d = ST_BLANK;
          if (req[0]) begin
            target_d = SRC_1;
          end else begin
            target_d = SRC_BG;
          end
        end
      end
      default: begin
        state_d  = ST_BG;
        target_d = SRC_BG;
      end
    endcase
  end

  // Output selection from the upcoming state so outputs move with the state
  always_comb begin
    digits_d = BLANK_DIGITS;
    dp_d     = '0;
    gnt_d    = 2'b00;
    active_d = SRC_BLANK;
    case (state_d)
      ST_BG: begin
        digits_d = src0_digits;
        dp_d     = src0_dp;
        active_d = SRC_BG;
      end
      ST_SHOW1: begin
        digits_d = src1_digits;
        dp_d     = src1_dp;
        gnt_d    = 2'b01;
        active_d = SRC_1;
      end
      ST_SHOW2: begin
        digits_d = src2_digits;
        dp_d     = src2_dp;
        gnt_d    = 2'b10;
        active_d = SRC_2;
      end
      default: begin
        active_d = SRC_BLANK;
      end
    endcase
  end

  // State, timer and output registers; reset aborts any hold or blank at once
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BG;
      target_q <= SRC_BG;
      ms_q     <= '0;
      digits_q <= BLANK_DIGITS;
      dp_q     <= '0;
      gnt_q    <= 2'b00;
      active_q <= SRC_BG;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ms_q     <= ms_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      gnt_q    <= gnt_d;
      active_q <= active_d;
    end
  end

  assign bit_7      = digits_q[31:28];
  assign bit_6      = digits_q[27:24];
  assign bit_5      = digits_q[23:20];
  assign bit_4      = digits_q[19:16];
  assign bit_3      = digits_q[15:12];
  assign bit_2      = digits_q[11:8];
  assign bit_1      = digits_q[7:4];
  assign bit_0      = digits_q[3:0];
  assign dp_en      = dp_q;
  assign gnt        = gnt_q;
  assign active_src = active_q;

endmodule
